// File: rtl/adc_scan_controller.sv
// Purpose : round-robin scan of up to 8 channels on a 10-bit SPI (mode 0) ADC; each result is offered on a valid/ready port.
// Latency : sampleValid rises 33*DIV clocks after the adcCsN fall; busy drops DIV clocks after that.
// Backpr. : no new frame starts while sampleValid is high; the result is held, never dropped or overwritten.
//
// Ports:
//   clockIn, reset           system clock (posedge), asynchronous active-high reset
//   enable, channelMask      start permission and scan set (bit n = channel n)
//   adcCsN/adcSclk/adcMosi   ADC pins driven by this block (all registered)
//   adcMiso                  ADC data in, sampled on the rising SCLK tick
//   sampleData/Channel/Valid result port, held until sampleValid && sampleReady
//   sampleReady              consumer accept
//   busy                     high whenever the sequencer is not idle
module adc_scan_controller #(
    parameter int DIV       = 4,
    parameter int DATA_BITS = 10
) (
    input  logic                 clockIn,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [7:0]           channelMask,
    output logic                 adcCsN,
    output logic                 adcSclk,
    output logic                 adcMosi,
    input  logic                 adcMiso,
    output logic [DATA_BITS-1:0] sampleData,
    output logic [2:0]           sampleChannel,
    output logic                 sampleValid,
    input  logic                 sampleReady,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

    localparam logic [15:0] TICK_RELOAD    = 16'(DIV - 1);
    localparam logic [4:0]  LAST_BIT       = 5'(5 + DATA_BITS);
    localparam logic [4:0]  FIRST_DATA_BIT = 5'd6;

    state_t               r_state, w_state;
    logic                 r_phase_fall, w_phase_fall;
    logic [4:0]           r_bit, w_bit;
    logic [15:0]          r_tick_cnt;
    logic                 w_tick;
    logic [2:0]           r_ch, w_ch;
    logic [2:0]           r_last_ch, w_last_ch;
    logic [2:0]           w_next_ch;
    logic                 r_cs_n, w_cs_n;
    logic                 r_sclk, w_sclk;
    logic                 r_mosi, w_mosi;
    logic [DATA_BITS-1:0] r_shift, w_shift;
    logic [DATA_BITS-1:0] r_data, w_data;
    logic [2:0]           r_sample_ch, w_sample_ch;
    logic                 r_valid, w_valid;

    // Command bits in wire order: start, single-ended, ch[2], ch[1], ch[0]; zero afterwards.
    function automatic logic cmd_bit(input logic [2:0] ch, input logic [4:0] idx);
        case (idx)
            5'd0:    return 1'b1;
            5'd1:    return 1'b1;
            5'd2:    return ch[2];
            5'd3:    return ch[1];
            5'd4:    return ch[0];
            default: return 1'b0;
        endcase
    endfunction

    // Bit-rate divider: parked at reload while idle so every frame starts with a full tick period.
    always_ff @(posedge clockIn or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= TICK_RELOAD;
        end else if (r_state == IDLE || r_tick_cnt == 16'd0) begin
            r_tick_cnt <= TICK_RELOAD;
        end else begin
            r_tick_cnt <= r_tick_cnt - 16'd1;
        end
    end

    assign w_tick = (r_state != IDLE) && (r_tick_cnt == 16'd0);

    // First enabled channel after the last one scanned, wrapping 7 -> 0.
    // The loop runs from the farthest candidate to the nearest so the nearest wins;
    // offset 8 wraps to the last channel itself (single-bit mask case).
    always_comb begin
        w_next_ch = r_last_ch;
        for (int k = 8; k >= 1; k--) begin
            if (channelMask[r_last_ch + 3'(k)]) begin
                w_next_ch = r_last_ch + 3'(k);
            end
        end
    end

    always_ff @(posedge clockIn or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_phase_fall <= 1'b0;
            r_bit        <= 5'd0;
            r_ch         <= 3'd0;
            r_last_ch    <= 3'd7;
            r_cs_n       <= 1'b1;
            r_sclk       <= 1'b0;
            r_mosi       <= 1'b0;
            r_shift      <= '0;
            r_data       <= '0;
            r_sample_ch  <= 3'd0;
            r_valid      <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_phase_fall <= w_phase_fall;
            r_bit        <= w_bit;
            r_ch         <= w_ch;
            r_last_ch    <= w_last_ch;
            r_cs_n       <= w_cs_n;
            r_sclk       <= w_sclk;
            r_mosi       <= w_mosi;
            r_shift      <= w_shift;
            r_data       <= w_data;
            r_sample_ch  <= w_sample_ch;
            r_valid      <= w_valid;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_phase_fall = r_phase_fall;
        w_bit        = r_bit;
        w_ch         = r_ch;
        w_last_ch    = r_last_ch;
        w_cs_n       = r_cs_n;
        w_sclk       = r_sclk;
        w_mosi       = r_mosi;
        w_shift      = r_shift;
        w_data       = r_data;
        w_sample_ch  = r_sample_ch;
        w_valid      = r_valid;

        if (r_valid && sampleReady) begin
            w_valid = 1'b0;
        end

        case (r_state)
            IDLE: begin
                // A pending result blocks the next start: backpressure stalls the scan.
                if (enable && (channelMask != 8'd0) && !r_valid) begin
                    w_ch      = w_next_ch;
                    w_last_ch = w_next_ch;
                    w_cs_n    = 1'b0;
                    w_state   = SETUP;
                end
            end
            SETUP: begin
                if (w_tick) begin
                    w_mosi       = cmd_bit(r_ch, 5'd0);
                    w_bit        = 5'd0;
                    w_phase_fall = 1'b0;
                    w_state      = SHIFT;
                end
            end
            SHIFT: begin
                if (w_tick) begin
                    if (!r_phase_fall) begin
                        w_sclk = 1'b1;
                        // Bits before FIRST_DATA_BIT are command time and the ADC null bit.
                        if (r_bit >= FIRST_DATA_BIT) begin
                            w_shift = {r_shift[DATA_BITS-2:0], adcMiso};
                        end
                        w_phase_fall = 1'b1;
                    end else begin
                        w_sclk = 1'b0;
                        if (r_bit < LAST_BIT) begin
                            w_bit        = r_bit + 5'd1;
                            w_mosi       = cmd_bit(r_ch, r_bit + 5'd1);
                            w_phase_fall = 1'b0;
                        end else begin
                            w_cs_n      = 1'b1;
                            w_mosi      = 1'b0;
                            w_data      = r_shift;
                            w_sample_ch = r_ch;
                            w_valid     = 1'b1;
                            w_state     = GAP;
                        end
                    end
                end
            end
            GAP: begin
                // One tick of chip-select high before the next frame may begin.
                if (w_tick) begin
                    w_state = IDLE;
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign adcCsN        = r_cs_n;
    assign adcSclk       = r_sclk;
    assign adcMosi       = r_mosi;
    assign sampleData    = r_data;
    assign sampleChannel = r_sample_ch;
    assign sampleValid   = r_valid;
    assign busy          = (r_state != IDLE);

endmodule
